// File: rtl/iter_control_if.sv
`default_nettype none
// ============================================================================
//  Module   : iter_control_if
//  Purpose  : Host <-> iteration-controller handshake bundle. The host owns
//             run/hold/abort/ack; the controller drives the datapath
//             enables, the iteration index and the sticky done flag.
//  Revision : 1.0 - initial release
// ============================================================================
interface iter_control_if #(
  parameter int CNTW = 5
);
  logic            run;
  logic            hold;
  logic            abort;
  logic            ack;
  logic            busy;
  logic            start;
  logic            step;
  logic            stop;
  logic [CNTW-1:0] iter;
  logic            done;

  // Host side: issues requests, observes status.
  modport master (
    output run, hold, abort, ack,
    input  busy, start, step, stop, iter, done
  );

  // Controller side.
  modport slave (
    input  run, hold, abort, ack,
    output busy, start, step, stop, iter, done
  );
endinterface
`default_nettype wire

// File: rtl/iter_control.sv
`default_nettype none
// ============================================================================
//  Module   : iter_control
//  Purpose  : Sequencer for multi-cycle iterative datapaths. A one-cycle run
//             request produces start, NITER step enables (stallable by hold),
//             then stop; abort cancels at any point and done is a sticky
//             result-valid flag cleared by ack or by the next accepted run.
//  Revision : 1.0 - initial release
// ============================================================================
module iter_control #(
  parameter int NITER = 16,
  parameter int CNTW  = 5
) (
  input  wire logic       clock,
  input  wire logic       reset,   // asynchronous, active-low
  iter_control_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_ITER  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [CNTW-1:0] c_last = CNTW'(NITER - 1);
  localparam logic [CNTW-1:0] c_one  = CNTW'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            w_accept;
  logic            w_cancel;

  // A run is only taken in IDLE, and a simultaneous abort vetoes it.
  assign w_accept = (r_state == S_IDLE) && bus.run && !bus.abort;
  // Abort only matters once an operation is in flight.
  assign w_cancel = (r_state != S_IDLE) && bus.abort;

  // Next state, iteration counter and done flag.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = r_done;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_state_nxt = S_ITER;
        w_cnt_nxt   = '0;
      end
      S_ITER: begin
        if (!bus.hold) begin
          if (r_cnt == c_last) begin
            w_state_nxt = S_STOP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_one;
          end
        end
      end
      S_STOP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Abort overrides every in-flight transition, including ITER->STOP.
    if (w_cancel) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end

    // Setting on completion beats a coincident ack.
    if ((r_state == S_STOP) && !bus.abort) begin
      w_done_nxt = 1'b1;
    end else if (w_accept || bus.ack) begin
      w_done_nxt = 1'b0;
    end
  end

  // State, counter and done registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Status decoded from registers only; step alone follows hold directly.
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.start = (r_state == S_START);
  assign bus.stop  = (r_state == S_STOP);
  assign bus.step  = (r_state == S_ITER) && !bus.hold;
  assign bus.iter  = r_cnt;
  assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_iter_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iter_control
//  Purpose  : Directed bench for iter_control: NITER=16 main instance plus
//             NITER=1 and NITER=31 instances. Per-operation expectations
//             (busy length, step/stop counts, final done) are queued when an
//             operation is launched and retired when busy falls.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iter_control;

  typedef struct {
    int   id;
    int   busy_len;
    int   steps;
    int   stops;
    logic done;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int   ntests = 0;
  int   nfail  = 0;
  exp_t sbq[$];

  iter_control_if #(.CNTW(5)) m_if ();
  iter_control_if #(.CNTW(1)) a_if ();
  iter_control_if #(.CNTW(5)) b_if ();

  iter_control #(.NITER(16), .CNTW(5)) u_main (.clock(clk), .reset(rst_n), .bus(m_if.slave));
  iter_control #(.NITER(1),  .CNTW(1)) u_min  (.clock(clk), .reset(rst_n), .bus(a_if.slave));
  iter_control #(.NITER(31), .CNTW(5)) u_max  (.clock(clk), .reset(rst_n), .bus(b_if.slave));

  always #5 clk = ~clk;

  logic [2:0] v_busy, v_step, v_stop, v_done;
  assign v_busy = {b_if.busy, a_if.busy, m_if.busy};
  assign v_step = {b_if.step, a_if.step, m_if.step};
  assign v_stop = {b_if.stop, a_if.stop, m_if.stop};
  assign v_done = {b_if.done, a_if.done, m_if.done};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input int bl, input int st, input int sp, input logic dn);
    exp_t e;
    e.id = id; e.busy_len = bl; e.steps = st; e.stops = sp; e.done = dn;
    sbq.push_back(e);
  endtask

  // Nominal main-instance operation: ends one cycle into IDLE with done set.
  task automatic run_main();
    push(0, 18, 16, 1, 1'b1);
    m_if.run = 1'b1;
    tick();
    m_if.run = 1'b0;
    repeat (18) tick();
    chk("main_done", m_if.done, 1);
  endtask

  // Per-instance monitor: accumulates an operation and retires it on busy fall.
  int   mb[3], ms[3], mp[3];
  logic pb[3];
  initial for (int k = 0; k < 3; k++) begin mb[k] = 0; ms[k] = 0; mp[k] = 0; pb[k] = 1'b0; end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mb[i] = 0; ms[i] = 0; mp[i] = 0; pb[i] = 1'b0;
      end else begin
        if (v_busy[i]) begin
          mb[i]++;
          if (v_step[i]) ms[i]++;
          if (v_stop[i]) mp[i]++;
        end else if (pb[i]) begin
          chk("sb_has_entry", (sbq.size() > 0), 1);
          if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_id",       i,         e.id);
            chk("sb_busy_len", mb[i],     e.busy_len);
            chk("sb_steps",    ms[i],     e.steps);
            chk("sb_stops",    mp[i],     e.stops);
            chk("sb_done",     v_done[i], e.done);
          end
          mb[i] = 0; ms[i] = 0; mp[i] = 0;
        end
        pb[i] = v_busy[i];
      end
    end
  end

  initial begin
    m_if.run = 0; m_if.hold = 0; m_if.abort = 0; m_if.ack = 0;
    a_if.run = 0; a_if.hold = 0; a_if.abort = 0; a_if.ack = 0;
    b_if.run = 0; b_if.hold = 0; b_if.abort = 0; b_if.ack = 0;

    // Reset values, observed while reset is asserted.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy",  m_if.busy,  0);
    chk("rst_start", m_if.start, 0);
    chk("rst_step",  m_if.step,  0);
    chk("rst_stop",  m_if.stop,  0);
    chk("rst_iter",  m_if.iter,  0);
    chk("rst_done",  m_if.done,  0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic run, no holds.
    push(0, 18, 16, 1, 1'b1);
    m_if.run = 1'b1;
    tick();
    m_if.run = 1'b0;
    chk("basic_start", m_if.start, 1);
    chk("basic_busy",  m_if.busy,  1);
    chk("basic_nostep", m_if.step, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("basic_step", m_if.step, 1);
      chk("basic_iter", m_if.iter, i);
    end
    tick();
    chk("basic_stop",     m_if.stop, 1);
    chk("basic_pre_done", m_if.done, 0);
    tick();
    chk("basic_done", m_if.done, 1);
    chk("basic_idle", m_if.busy, 0);
    repeat (3) tick();
    chk("basic_sticky", m_if.done, 1);
    m_if.ack = 1'b1; tick(); m_if.ack = 1'b0;
    chk("basic_ack", m_if.done, 0);

    // Stall three cycles at iter=5.
    push(0, 21, 16, 1, 1'b1);
    m_if.run = 1'b1; tick(); m_if.run = 1'b0;
    tick();
    repeat (5) tick();
    m_if.hold = 1'b1;
    #1;
    for (int j = 0; j < 3; j++) begin
      chk("stall_step", m_if.step, 0);
      chk("stall_iter", m_if.iter, 5);
      tick();
    end
    m_if.hold = 1'b0;
    #1;
    chk("stall_resume_iter", m_if.iter, 5);
    chk("stall_resume_step", m_if.step, 1);
    repeat (11) tick();
    chk("stall_stop", m_if.stop, 1);
    tick();
    chk("stall_done", m_if.done, 1);
    m_if.ack = 1'b1; tick(); m_if.ack = 1'b0;

    // Abort at iter=7, then a normal run.
    push(0, 9, 8, 0, 1'b0);
    m_if.run = 1'b1; tick(); m_if.run = 1'b0;
    tick();
    repeat (7) tick();
    chk("abort_iter7", m_if.iter, 7);
    m_if.abort = 1'b1;
    #1;
    chk("abort_cycle_step", m_if.step, 1);
    tick();
    m_if.abort = 1'b0;
    chk("abort_busy", m_if.busy, 0);
    chk("abort_iter", m_if.iter, 0);
    repeat (3) begin
      chk("abort_nostop", m_if.stop, 0);
      chk("abort_nodone", m_if.done, 0);
      tick();
    end
    run_main();
    m_if.ack = 1'b1; tick(); m_if.ack = 1'b0;

    // run held through ITER and STOP: no second operation.
    push(0, 18, 16, 1, 1'b1);
    m_if.run = 1'b1; tick(); m_if.run = 1'b0;
    tick();
    m_if.run = 1'b1;
    repeat (16) tick();
    chk("ign_stop", m_if.stop, 1);
    tick();
    m_if.run = 1'b0;
    chk("ign_idle", m_if.busy, 0);
    tick();
    chk("ign_nobusy",  m_if.busy,  0);
    chk("ign_nostart", m_if.start, 0);
    chk("ign_done",    m_if.done,  1);

    // run+abort in IDLE: ignored, done untouched.
    m_if.run = 1'b1; m_if.abort = 1'b1;
    tick();
    m_if.run = 1'b0; m_if.abort = 1'b0;
    chk("ra_busy",  m_if.busy,  0);
    chk("ra_start", m_if.start, 0);
    chk("ra_done",  m_if.done,  1);
    tick();
    chk("ra_still_idle", m_if.busy, 0);
    m_if.ack = 1'b1; tick(); m_if.ack = 1'b0;
    chk("ra_ack", m_if.done, 0);

    // ack coincident with STOP->IDLE: set wins.
    push(0, 18, 16, 1, 1'b1);
    m_if.run = 1'b1; tick(); m_if.run = 1'b0;
    repeat (17) tick();
    chk("ackc_stop", m_if.stop, 1);
    m_if.ack = 1'b1; tick(); m_if.ack = 1'b0;
    chk("ackc_done", m_if.done, 1);
    m_if.ack = 1'b1; tick(); m_if.ack = 1'b0;
    chk("ackc_clear", m_if.done, 0);

    // Asynchronous reset mid-ITER, between edges.
    m_if.run = 1'b1; tick(); m_if.run = 1'b0;
    repeat (5) tick();
    chk("ar_pre_step", m_if.step, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy",  m_if.busy,  0);
    chk("ar_step",  m_if.step,  0);
    chk("ar_iter",  m_if.iter,  0);
    chk("ar_start", m_if.start, 0);
    chk("ar_stop",  m_if.stop,  0);
    chk("ar_done",  m_if.done,  0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_idle", m_if.busy, 0);
    run_main();
    m_if.ack = 1'b1; tick(); m_if.ack = 1'b0;

    // NITER=1.
    push(1, 3, 1, 1, 1'b1);
    a_if.run = 1'b1; tick(); a_if.run = 1'b0;
    chk("min_start", a_if.start, 1);
    tick();
    chk("min_step", a_if.step, 1);
    chk("min_iter", a_if.iter, 0);
    tick();
    chk("min_stop", a_if.stop, 1);
    tick();
    chk("min_done", a_if.done, 1);

    // NITER=31.
    push(2, 33, 31, 1, 1'b1);
    b_if.run = 1'b1; tick(); b_if.run = 1'b0;
    repeat (31) tick();
    chk("max_iter_last", b_if.iter, 30);
    tick();
    chk("max_stop", b_if.stop, 1);
    tick();
    chk("max_done", b_if.done, 1);

    repeat (2) tick();
    chk("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
